// File: rtl/matrix_pkg.sv
// Shared definitions for the LED matrix scan controller: pattern codes and selector width.
package matrix_pkg;

  localparam int unsigned PAT_W = 2;

  localparam logic [PAT_W-1:0] PAT_BLANK = 2'd0;
  localparam logic [PAT_W-1:0] PAT_BOX   = 2'd1;
  localparam logic [PAT_W-1:0] PAT_FULL  = 2'd2;
  localparam logic [PAT_W-1:0] PAT_CHECK = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

endpackage

// File: rtl/matrix_scan_ctrl_if.sv
// Control/display bundle between a matrix scan controller and its user.
interface matrix_scan_ctrl_if
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS = 16,
  parameter int unsigned COLS = 16
);

  logic                      en;
  logic [PAT_W-1:0]          pat_sel;
  logic [$clog2(ROWS)-1:0]   row_bin;
  logic [ROWS-1:0]           row_sel;
  logic [COLS-1:0]           col;
  logic                      frame_tick;

  modport master (
    output en, pat_sel,
    input  row_bin, row_sel, col, frame_tick
  );

  modport slave (
    input  en, pat_sel,
    output row_bin, row_sel, col, frame_tick
  );

endinterface

// File: rtl/matrix_pattern_rom.sv
// Combinational pattern generator: (row, pattern) -> column bits, bit COLS-1 leftmost.
module matrix_pattern_rom
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS = 16,
  parameter int unsigned COLS = 16
) (
  input  logic [$clog2(ROWS)-1:0] row,
  input  logic [PAT_W-1:0]        pat,
  output logic [COLS-1:0]         data_c
);

  int unsigned row_i;
  assign row_i = 32'(row);

  always_comb begin
    data_c = '0;
    case (pat)
      PAT_FULL: data_c = '1;
      PAT_BOX: begin
        for (int unsigned c = 0; c < COLS; c++) begin
          // top/bottom edges span cols 4..COLS-5, sides sit on cols 4 and COLS-5
          if ((row_i == 1 || row_i == ROWS - 3) && c >= 4 && c <= COLS - 5)
            data_c[c] = 1'b1;
          else if (row_i >= 2 && row_i <= ROWS - 4 && (c == 4 || c == COLS - 5))
            data_c[c] = 1'b1;
        end
      end
      PAT_CHECK: begin
        for (int unsigned c = 0; c < COLS; c++)
          data_c[c] = (((row_i + c) & 32'd1) == 32'd0);
      end
      default: data_c = '0;
    endcase
  end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row-multiplexed LED matrix scanner with frame-synchronous pattern switching.
// Optional horizontal scroll compiled in with `define MATRIX_SCROLL_EN.
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS          = 16,
  parameter int unsigned COLS          = 16,
  parameter int unsigned SCAN_DIV      = 1000,
  parameter int unsigned SCROLL_FRAMES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  matrix_scan_ctrl_if.slave bus
);

  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned DIV_W = $clog2(SCAN_DIV);

  if (ROWS < 2 || COLS < 8 || SCAN_DIV < 2 || SCROLL_FRAMES < 1) begin : g_bad_param
    $error("matrix_scan_ctrl: illegal parameter value");
  end

  scan_state_e      state_q, state_nxt;
  logic [DIV_W-1:0] div_q, div_nxt;
  logic [ROW_W-1:0] row_q, row_nxt;
  logic [PAT_W-1:0] pat_q, pat_nxt;
  logic             active_c, wrap_c;
  logic [COLS-1:0]  rom_c, col_c;
  logic [ROWS-1:0]  row_sel_q;
  logic [COLS-1:0]  col_q;
  logic             tick_q;

  // Next-state: divider, row index and frame-synchronous pattern latch
  always_comb begin
    state_nxt = state_q;
    div_nxt   = div_q;
    row_nxt   = row_q;
    pat_nxt   = pat_q;
    active_c  = 1'b0;
    wrap_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.en) begin
          state_nxt = ST_SCAN;
          div_nxt   = '0;
          row_nxt   = '0;
          pat_nxt   = bus.pat_sel;
          active_c  = 1'b1;
        end
      end
      ST_SCAN: begin
        if (!bus.en) begin
          state_nxt = ST_IDLE;
          div_nxt   = '0;
          row_nxt   = '0;
        end else begin
          active_c = 1'b1;
          if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_nxt = '0;
            if (row_q == ROW_W'(ROWS - 1)) begin
              row_nxt = '0;
              pat_nxt = bus.pat_sel;
              wrap_c  = 1'b1;
            end else begin
              row_nxt = row_q + ROW_W'(1);
            end
          end else begin
            div_nxt = div_q + DIV_W'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pattern looked up for the row/pattern that will be shown next cycle
  matrix_pattern_rom #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_rom (
    .row    (row_nxt),
    .pat    (pat_nxt),
    .data_c (rom_c)
  );

`ifdef MATRIX_SCROLL_EN
  localparam int unsigned OFF_W  = $clog2(COLS);
  localparam int unsigned FCNT_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  logic [OFF_W-1:0]  off_q, off_nxt;
  logic [FCNT_W-1:0] fcnt_q, fcnt_nxt;
  logic [2*COLS-1:0] dbl_c;

  // Offset steps once per SCROLL_FRAMES wraps; rotation via doubled word
  always_comb begin
    off_nxt  = off_q;
    fcnt_nxt = fcnt_q;
    if (!active_c) begin
      off_nxt  = '0;
      fcnt_nxt = '0;
    end else if (wrap_c) begin
      if (fcnt_q == FCNT_W'(SCROLL_FRAMES - 1)) begin
        fcnt_nxt = '0;
        off_nxt  = (off_q == OFF_W'(COLS - 1)) ? '0 : off_q + OFF_W'(1);
      end else begin
        fcnt_nxt = fcnt_q + FCNT_W'(1);
      end
    end
    dbl_c = {rom_c, rom_c} << off_nxt;
    col_c = dbl_c[2*COLS-1 -: COLS];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q  <= '0;
      fcnt_q <= '0;
    end else begin
      off_q  <= off_nxt;
      fcnt_q <= fcnt_nxt;
    end
  end
`else
  assign col_c = rom_c;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      row_q     <= '0;
      pat_q     <= PAT_BLANK;
      row_sel_q <= '0;
      col_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      div_q     <= div_nxt;
      row_q     <= row_nxt;
      pat_q     <= pat_nxt;
      row_sel_q <= active_c ? (ROWS'(1'b1) << row_nxt) : '0;
      col_q     <= active_c ? col_c : '0;
      tick_q    <= wrap_c;
    end
  end

  assign bus.row_bin    = row_q;
  assign bus.row_sel    = row_sel_q;
  assign bus.col        = col_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Scoreboard bench for matrix_scan_ctrl, 16x16 with a 4-cycle row dwell.
module tb_matrix_scan_ctrl;

  localparam int unsigned ROWS     = 16;
  localparam int unsigned COLS     = 16;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned FRAME    = ROWS * SCAN_DIV;

  logic clk;
  logic rst_n;

  matrix_scan_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  matrix_scan_ctrl #(
    .ROWS          (ROWS),
    .COLS          (COLS),
    .SCAN_DIV      (SCAN_DIV),
    .SCROLL_FRAMES (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int ticks    = 0;

  logic [36:0] sb[$];
  logic [3:0]  prev_row = 4'd0;

  bit          m_active = 1'b0;
  int          m_t      = 0;
  logic [1:0]  m_pat    = 2'd0;
  int          m_off    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_pattern(input logic [1:0] p, input int r);
    case (p)
      2'd0: return 16'h0000;
      2'd1: begin
        if (r == 1 || r == 13) return 16'h0FF0;
        if (r >= 2 && r <= 12) return 16'h0810;
        return 16'h0000;
      end
      2'd2: return 16'hFFFF;
      default: return (r % 2 == 0) ? 16'h5555 : 16'hAAAA;
    endcase
  endfunction

  function automatic logic [15:0] rotl(input logic [15:0] v, input int k);
    logic [15:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[(i + k) % 16] = v[i];
    return o;
  endfunction

  // Reference model advanced with the inputs about to be sampled; expected word queued
  task automatic step();
    logic [36:0] e, got;
    logic        tick;
    int          r;
    tick = 1'b0;
    if (!bus.en) begin
      m_active = 1'b0;
      m_off    = 0;
      e        = '0;
    end else begin
      if (!m_active) begin
        m_active = 1'b1;
        m_t      = 0;
        m_pat    = bus.pat_sel;
      end else begin
        m_t = (m_t + 1) % FRAME;
        if (m_t == 0) begin
          m_pat = bus.pat_sel;
          tick  = 1'b1;
`ifdef MATRIX_SCROLL_EN
          m_off = (m_off + 1) % COLS;
`endif
        end
      end
      r = m_t / SCAN_DIV;
      e = {4'(r), 16'(1) << r, rotl(exp_pattern(m_pat, r), m_off), tick};
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = {bus.row_bin, bus.row_sel, bus.col, bus.frame_tick};
    e = sb.pop_front();
    check("cycle", 64'(got), 64'(e));
    if (bus.frame_tick) begin
      ticks++;
      check("tick_row", 64'({prev_row, bus.row_bin}), 64'({4'd15, 4'd0}));
    end
    prev_row = bus.row_bin;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.en      = 1'b0;
    bus.pat_sel = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_row_bin", 64'(bus.row_bin), 64'd0);
    check("rst_row_sel", 64'(bus.row_sel), 64'd0);
    check("rst_col", 64'(bus.col), 64'd0);
    check("rst_tick", 64'(bus.frame_tick), 64'd0);
    rst_n = 1'b1;

    // Idle after reset until en rises
    repeat (5) step();

    // Hollow box, two full frames
    bus.en = 1'b1;
    step();
    check("start_sel", 64'(bus.row_sel), 64'h0001);
    ticks = 0;
    for (int i = 0; i < FRAME - 1; i++) begin
      step();
      if (m_t == 1 * SCAN_DIV + 2)  check("box_r1", 64'(bus.col), 64'(rotl(16'h0FF0, m_off)));
      if (m_t == 5 * SCAN_DIV + 1)  check("box_r5", 64'(bus.col), 64'(rotl(16'h0810, m_off)));
      if (m_t == 13 * SCAN_DIV + 3) check("box_r13", 64'(bus.col), 64'(rotl(16'h0FF0, m_off)));
      if (m_t == 14 * SCAN_DIV)     check("box_r14", 64'(bus.col), 64'h0000);
    end
    check("no_tick_start", 64'(ticks), 64'd0);
    for (int i = 0; i < FRAME; i++) step();
    check("ticks_1frame", 64'(ticks), 64'd1);
    for (int i = 0; i < FRAME; i++) step();
    check("ticks_2frames", 64'(ticks), 64'd2);

    // Pattern switch at row 7 takes effect only at the next wrap
    for (int i = 0; i < FRAME && m_t != 7 * SCAN_DIV; i++) step();
    bus.pat_sel = 2'd2;
    for (int i = 0; i < FRAME && m_t != 0; i++) begin
      step();
      if (m_t == 12 * SCAN_DIV + 1) check("hold_r12", 64'(bus.col), 64'(rotl(16'h0810, m_off)));
    end
    check("full_r0", 64'(bus.col), 64'hFFFF);
    for (int i = 0; i < 10; i++) step();

    // Drop en mid-dwell of row 9, then restart with blank pattern
    for (int i = 0; i < FRAME && m_t != 9 * SCAN_DIV + 2; i++) step();
    bus.en = 1'b0;
    step();
    check("off_sel", 64'(bus.row_sel), 64'd0);
    check("off_col", 64'(bus.col), 64'd0);
    repeat (3) step();
    bus.pat_sel = 2'd0;
    bus.en      = 1'b1;
    step();
    check("restart_row", 64'(bus.row_bin), 64'd0);
    check("restart_tick", 64'(bus.frame_tick), 64'd0);
    for (int i = 0; i < 30; i++) step();

    // Asynchronous reset mid-frame, then checkerboard restart
    bus.pat_sel = 2'd2;
    for (int i = 0; i < FRAME; i++) step();
    rst_n = 1'b0;
    #1;
    check("arst_row_bin", 64'(bus.row_bin), 64'd0);
    check("arst_row_sel", 64'(bus.row_sel), 64'd0);
    check("arst_col", 64'(bus.col), 64'd0);
    check("arst_tick", 64'(bus.frame_tick), 64'd0);
    m_active    = 1'b0;
    m_pat       = 2'd0;
    m_off       = 0;
    prev_row    = 4'd0;
    bus.pat_sel = 2'd3;
    #2;
    rst_n = 1'b1;
    step();
    check("ck_r0", 64'(bus.col), 64'h5555);
    for (int i = 0; i < FRAME + 8; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
